// File: rtl/clause_table_loader.sv
// clause_table_loader: packs a 32-bit clause-image stream into clause table rows and writes them out
// Optional feature: define LOADER_CHECKSUM_EN to add checksum_o (running XOR of accepted beats).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, row_count_i         begin a load of row_count_i rows (sampled in IDLE only)
//   s_tdata_i/tvalid_i/tlast_i   stream input, s_tready_o stream ready
//   wr_en_o, wr_addr_o           one-cycle table write strobe and row address
//   wr_clauses_o                 assembled row
//   busy_o, done_o, error_o      status: loading, end-of-load pulse, sticky error
//   checksum_o                   XOR of accepted beats (LOADER_CHECKSUM_EN only)
module clause_table_loader #(
   parameter int CLAUSE_COUNT           = 20,
   parameter int DEPTH                  = 2048,
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int NSAT                   = 3,
   parameter int S_WIDTH                = 32,
   localparam int VAW                   = VARIABLE_ADDRESS_WIDTH,
   localparam int CT_WIDTH              = (VAW + 1) * (NSAT - 1) * CLAUSE_COUNT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [VAW:0]        row_count_i,
   input  logic [S_WIDTH-1:0]  s_tdata_i,
   input  logic                s_tvalid_i,
   input  logic                s_tlast_i,
   output logic                s_tready_o,
   output logic                wr_en_o,
   output logic [VAW-1:0]      wr_addr_o,
   output logic [CT_WIDTH-1:0] wr_clauses_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o
`ifdef LOADER_CHECKSUM_EN
   ,output logic [S_WIDTH-1:0] checksum_o
`endif
);
   localparam int BEATS = (CT_WIDTH + S_WIDTH - 1) / S_WIDTH;
   localparam int BUF_W = BEATS * S_WIDTH;
   localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [VAW-1:0]  row_q, row_d;
   logic [VAW:0]    rows_q, rows_d;
   logic [BUF_W-1:0] buf_q, buf_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic            accept, last_beat, final_row;

   assign accept    = state_q == LOAD && s_tvalid_i;
   assign last_beat = beat_q == BW'(BEATS - 1);
   assign final_row = {1'b0, row_q} == rows_q - 1'b1;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      row_d   = row_q;
      rows_d  = rows_q;
      buf_d   = buf_q;
      error_d = error_q;
      done_d  = state_q == DONE;
      case (state_q)
         IDLE: if (start_i) begin
            rows_d  = row_count_i;
            row_d   = '0;
            beat_d  = '0;
            error_d = row_count_i > (VAW + 1)'(DEPTH);
            state_d = (row_count_i == '0 || error_d) ? DONE : LOAD;
         end
         LOAD: if (accept) begin
            buf_d[beat_q * S_WIDTH +: S_WIDTH] = s_tdata_i;
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            // tlast is only legal on the very last beat of the image; anywhere else abort without writing
            if (s_tlast_i && !(last_beat && final_row)) begin
               error_d = 1'b1;
               state_d = DONE;
            end else if (last_beat) begin
               error_d = error_q | (final_row & ~s_tlast_i);
               state_d = WRITE;
            end
         end
         WRITE: begin
            row_d   = row_q + 1'b1;
            state_d = final_row ? DONE : LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         beat_q  <= '0;
         row_q   <= '0;
         rows_q  <= '0;
         buf_q   <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         row_q   <= row_d;
         rows_q  <= rows_d;
         buf_q   <= buf_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign s_tready_o   = state_q == LOAD;
   assign wr_en_o      = state_q == WRITE;
   assign busy_o       = state_q == LOAD || state_q == WRITE;
   assign wr_addr_o    = row_q;
   assign wr_clauses_o = buf_q[CT_WIDTH-1:0];
   assign done_o       = done_q;
   assign error_o      = error_q;

`ifdef LOADER_CHECKSUM_EN
   logic [S_WIDTH-1:0] sum_q, sum_d;

   always_comb sum_d = (state_q == IDLE && start_i) ? '0 : accept ? sum_q ^ s_tdata_i : sum_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sum_q <= '0;
      else sum_q <= sum_d;
   end

   assign checksum_o = sum_q;
`endif
endmodule

// File: tb/tb_clause_table_loader.sv
// tb_clause_table_loader: self-checking bench for clause_table_loader
module tb_clause_table_loader;
   localparam int CT    = 480;
   localparam int BEATS = 15;
   localparam int DEPTH = 2048;

   typedef struct {int addr; logic [CT-1:0] row;} wr_t;
   typedef struct {int rc; int nb; int tl; int exp_wr; bit exp_err;} vec_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [11:0]   row_count_i = '0;
   logic [31:0]   s_tdata_i = '0;
   logic          s_tvalid_i = 1'b0;
   logic          s_tlast_i = 1'b0;
   logic          s_tready_o, wr_en_o, busy_o, done_o, error_o;
   logic [10:0]   wr_addr_o;
   logic [CT-1:0] wr_clauses_o;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   checksum_o;
`endif

   clause_table_loader dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .row_count_i(row_count_i),
      .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i),
      .s_tready_o(s_tready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .wr_clauses_o(wr_clauses_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
`ifdef LOADER_CHECKSUM_EN
      , .checksum_o(checksum_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   wr_t         act_q[$];
   wr_t         exp_q[$];
   logic [31:0] d_q[$];
   bit          l_q[$];
   bit          exp_err;
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          tready_in_wr = 0;
   bit          done_err = 1'b0;

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (wr_en_o) act_q.push_back('{int'(wr_addr_o), wr_clauses_o});
         if (wr_en_o && s_tready_o) tready_in_wr++;
         if (done_o) begin
            done_cnt++;
            done_err = error_o;
         end
      end
   end

   task automatic chk(input string nm, input logic [CT-1:0] a, input logic [CT-1:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
      end
   endtask

   // Reference: walk the beat list; every BEATS beats form a row at address beat/BEATS
   task automatic model(input int rc);
      logic [CT-1:0] row;
      int total;
      exp_q.delete();
      exp_err = 1'b0;
      row = '0;
      total = rc * BEATS;
      if (rc > DEPTH) exp_err = 1'b1;
      else if (rc > 0) begin
         for (int k = 0; k < d_q.size(); k++) begin
            row[(k % BEATS) * 32 +: 32] = d_q[k];
            if (l_q[k] && k != total - 1) begin
               exp_err = 1'b1;
               break;
            end
            if (k % BEATS == BEATS - 1) exp_q.push_back('{k / BEATS, row});
            if (k == total - 1) begin
               if (!l_q[k]) exp_err = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic prep(input int rc, input int nb, input int tl, input int mode);
      d_q.delete();
      l_q.delete();
      for (int k = 0; k < nb; k++) begin
         d_q.push_back(mode == 0 ? 32'(k + 1) : mode == 1 ? $urandom : 32'hA5A5A5A5);
         l_q.push_back(k == tl);
      end
      model(rc);
      act_q.delete();
   endtask

   task automatic kick(input int rc);
      @(negedge clk_i);
      start_i = 1'b1;
      row_count_i = 12'(rc);
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic drive(input bit gaps);
      int i;
      int cyc;
      bit hold;
      i = 0;
      cyc = 0;
      hold = 1'b0;
      while (i < d_q.size() && cyc < 2000) begin
         if (!hold && gaps && $urandom_range(0, 2) == 0) s_tvalid_i = 1'b0;
         else begin
            s_tvalid_i = 1'b1;
            s_tdata_i = d_q[i];
            s_tlast_i = l_q[i];
         end
         hold = s_tvalid_i && !s_tready_o;
         if (s_tvalid_i && s_tready_o) i++;
         @(negedge clk_i);
         cyc++;
      end
      s_tvalid_i = 1'b0;
      s_tlast_i = 1'b0;
      chk("stream_beats_accepted", i, d_q.size());
   endtask

   task automatic finish(output int nw, output bit er);
      int c;
      int d0;
      d0 = done_cnt;
      c = 0;
      while (done_cnt == d0 && c < 300) begin
         @(negedge clk_i);
         c++;
      end
      if (done_cnt == d0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout waited=%0d cycles", c);
      end
      @(negedge clk_i);
      chk("write_count", act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         chk("write_addr", act_q[i].addr, exp_q[i].addr);
         chk("write_row", act_q[i].row, exp_q[i].row);
      end
      chk("error_at_done", done_err, exp_err);
      nw = act_q.size();
      er = done_err;
   endtask

   task automatic run_load(input int rc, input int nb, input int tl, input bit gaps, input int mode,
                           output int nw, output bit er);
      prep(rc, nb, tl, mode);
      kick(rc);
      drive(gaps);
      finish(nw, er);
   endtask

   vec_t vecs[8];
   int   nw;
   bit   er;

   initial begin
      vecs[0] = '{1, 15, 14, 1, 1'b0};
      vecs[1] = '{3, 45, 44, 3, 1'b0};
      vecs[2] = '{2, 20, 19, 1, 1'b1};
      vecs[3] = '{2049, 0, -1, 0, 1'b1};
      vecs[4] = '{0, 0, -1, 0, 1'b0};
      vecs[5] = '{1, 15, -1, 1, 1'b1};
      vecs[6] = '{2, 1, 0, 0, 1'b1};
      vecs[7] = '{4, 60, 59, 4, 1'b0};

      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_ctrl", {s_tready_o, wr_en_o, busy_o, done_o, error_o, wr_addr_o}, '0);
      chk("reset_row", wr_clauses_o, '0);

      for (int i = 0; i < 8; i++) begin
         run_load(vecs[i].rc, vecs[i].nb, vecs[i].tl, i == 1, 0, nw, er);
         chk("vec_writes", nw, vecs[i].exp_wr);
         chk("vec_error", er, vecs[i].exp_err);
         if (i == 0 && act_q.size() > 0) begin
            chk("row0_low_beat", act_q[0].row[31:0], 32'h1);
            chk("row0_high_beat", act_q[0].row[479:448], 32'hF);
         end
      end

      // Out-of-range count: no stream activity, done two cycles after start
      kick(2049);
      chk("bad_count_no_tready", s_tready_o, 1'b0);
      chk("bad_count_done_early", done_o, 1'b0);
      @(negedge clk_i);
      chk("bad_count_done", done_o, 1'b1);
      chk("bad_count_error", error_o, 1'b1);
      @(negedge clk_i);
      chk("done_one_cycle", done_o, 1'b0);

      // A fresh accepted start clears the sticky error
      prep(1, 15, 14, 1);
      kick(1);
      chk("error_cleared_on_start", error_o, 1'b0);
      chk("busy_in_load", busy_o, 1'b1);
      drive(1'b1);
      finish(nw, er);

      // Reset in the middle of row 1
      prep(2, 22, -1, 0);
      kick(2);
      drive(1'b0);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_mid_writes", act_q.size(), 1);
      chk("rst_mid_ctrl", {s_tready_o, wr_en_o, busy_o, done_o, error_o, wr_addr_o}, '0);
      chk("rst_mid_row", wr_clauses_o, '0);
      run_load(1, 15, 14, 1'b0, 1, nw, er);
      if (act_q.size() > 0) chk("restart_addr0", act_q[0].addr, 0);

`ifdef LOADER_CHECKSUM_EN
      run_load(1, 15, 14, 1'b0, 2, nw, er);
      chk("checksum", checksum_o, 32'hA5A5A5A5);
`endif

      for (int t = 0; t < 8; t++) begin
         int rc;
         int total;
         int mode;
         int tl;
         int nb;
         rc = $urandom_range(1, 3);
         total = rc * BEATS;
         mode = $urandom_range(0, 2);
         tl = mode == 0 ? total - 1 : mode == 1 ? -1 : $urandom_range(0, total - 2);
         nb = mode == 2 ? tl + 1 : total;
         run_load(rc, nb, tl, 1'b1, 1, nw, er);
      end

      chk("tready_low_in_write", tready_in_wr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
